// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave deserialiser/serialiser
// and the burst RAM controller.
`timescale 1ns/1ps
interface spi_ram_burst_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH+1:0] din;
  logic             rx_valid;
  logic [WIDTH-1:0] dout;
  logic             tx_valid;
  logic             cmd_err;

  modport master (
    output din, rx_valid,
    input  dout, tx_valid, cmd_err
  );

  modport slave (
    input  din, rx_valid,
    output dout, tx_valid, cmd_err
  );
endinterface

// File: rtl/spi_ram_burst.sv
// Single-port RAM controller for the SPI slave: opcode decode, independent
// write/read pointers with optional burst auto-increment and a sticky error flag.
`timescale 1ns/1ps
module spi_ram_burst #(
  parameter int WIDTH     = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_ram_burst_if.slave  bus
);

  localparam int              AW       = (MEM_DEPTH > 2) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [WIDTH:0]  DEPTH_V  = (WIDTH+1)'(MEM_DEPTH);
  localparam logic [AW-1:0]   LAST_PTR = AW'(MEM_DEPTH - 1);

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } arm_state_t;

  typedef enum logic [1:0] {
    OP_WRITE_ADD  = 2'b00,
    OP_WRITE_DATA = 2'b01,
    OP_READ_ADD   = 2'b10,
    OP_READ_DATA  = 2'b11
  } opcode_t;

  // Post-increment with wrap at the last legal word, not at the pointer width.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
  endfunction

  logic [WIDTH-1:0] mem [MEM_DEPTH];

  arm_state_t       state, state_n;
  logic [AW-1:0]    wr_ptr, wr_ptr_n;
  logic [AW-1:0]    rd_ptr, rd_ptr_n;
  logic             err, err_n;
  logic             wr_en, rd_en;

  opcode_t          op;
  logic [WIDTH-1:0] payload;
  logic             in_range;

  logic [WIDTH-1:0] dout_p1;
  logic             vld_p1;

  assign op       = opcode_t'(bus.din[WIDTH+1:WIDTH]);
  assign payload  = bus.din[WIDTH-1:0];
  assign in_range = ({1'b0, payload} < DEPTH_V);

  // p0: command decode, pointer/arming/error next-state
  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    err_n    = err;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    if (bus.rx_valid) begin
      unique case (op)
        OP_WRITE_ADD: begin
          if (in_range) wr_ptr_n = payload[AW-1:0];
          else          err_n    = 1'b1;
        end
        OP_WRITE_DATA: begin
          wr_en = 1'b1;
          if (AUTO_INC != 0) wr_ptr_n = next_ptr(wr_ptr);
        end
        OP_READ_ADD: begin
          if (in_range) begin
            rd_ptr_n = payload[AW-1:0];
            state_n  = ARMED;
          end else begin
            err_n = 1'b1;
          end
        end
        OP_READ_DATA: begin
          if (state == ARMED) begin
            rd_en = 1'b1;
            if (AUTO_INC != 0) rd_ptr_n = next_ptr(rd_ptr);
          end else begin
            err_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // p1: registered control state and read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNARMED;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err     <= 1'b0;
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      state   <= state_n;
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      err     <= err_n;
      vld_p1  <= rd_en;
      if (rd_en) dout_p1 <= mem[rd_ptr];
    end
  end

  // Storage survives reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= payload;
  end

  assign bus.dout     = dout_p1;
  assign bus.tx_valid = vld_p1;
  assign bus.cmd_err  = err;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: three configurations share one command
// stream and are checked every cycle against a queue/array-level model.
`timescale 1ns/1ps
module tb_spi_ram_burst;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  bit         cmp_en;

  int checks;
  int errors;

  spi_ram_burst_if #(.WIDTH(8)) bus0 ();
  spi_ram_burst_if #(.WIDTH(8)) bus1 ();
  spi_ram_burst_if #(.WIDTH(8)) bus2 ();

  assign bus0.din = din;  assign bus0.rx_valid = rx_valid;
  assign bus1.din = din;  assign bus1.rx_valid = rx_valid;
  assign bus2.din = din;  assign bus2.rx_valid = rx_valid;

  spi_ram_burst #(.WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_ram_burst #(.WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  spi_ram_burst #(.WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, one slot per instance
  int         depth [3] = '{256, 200, 256};
  int         inc   [3] = '{1, 1, 0};
  logic [7:0] mmem  [3][256];
  int         mwr   [3];
  int         mrd   [3];
  bit         marm  [3];
  bit         merr  [3];
  logic [7:0] mdout [3];
  bit         mvld  [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mwr[k] = 0; mrd[k] = 0; marm[k] = 0; merr[k] = 0;
      mdout[k] = 8'h00; mvld[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input logic [1:0] op, input logic [7:0] p);
    for (int k = 0; k < 3; k++) begin
      mvld[k] = 0;
      if (v) begin
        case (op)
          2'b00: if (int'(p) < depth[k]) mwr[k] = int'(p); else merr[k] = 1;
          2'b01: begin
            mmem[k][mwr[k]] = p;
            if (inc[k] != 0) mwr[k] = (mwr[k] + 1) % depth[k];
          end
          2'b10: if (int'(p) < depth[k]) begin mrd[k] = int'(p); marm[k] = 1; end
                 else merr[k] = 1;
          default: if (marm[k]) begin
            mdout[k] = mmem[k][mrd[k]];
            mvld[k]  = 1;
            if (inc[k] != 0) mrd[k] = (mrd[k] + 1) % depth[k];
          end else merr[k] = 1;
        endcase
      end
    end
  endtask

  task automatic cmp(input int k, input logic [7:0] d, input logic v, input logic e);
    chk($sformatf("u%0d.tx_valid", k), 32'(v), 32'(mvld[k]));
    chk($sformatf("u%0d.cmd_err", k),  32'(e), 32'(merr[k]));
    chk($sformatf("u%0d.dout", k),     32'(d), 32'(mdout[k]));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, bus0.dout, bus0.tx_valid, bus0.cmd_err);
      cmp(1, bus1.dout, bus1.tx_valid, bus1.cmd_err);
      cmp(2, bus2.dout, bus2.tx_valid, bus2.cmd_err);
    end
  end

  // Issue one command; returns at the negedge after it was sampled.
  task automatic cmd(input logic [1:0] op, input logic [7:0] p);
    din = {op, p};
    rx_valid = 1'b1;
    @(posedge clk);
    model_step(1'b1, op, p);
    @(negedge clk);
  endtask

  task automatic idle();
    din = 10'h3FF;
    rx_valid = 1'b0;
    @(posedge clk);
    model_step(1'b0, 2'b00, 8'h00);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst u0.dout", 32'(bus0.dout), 32'h0);
    chk("rst u0.tx_valid", 32'(bus0.tx_valid), 32'h0);
    chk("rst u1.cmd_err", 32'(bus1.cmd_err), 32'h0);
    chk("rst u2.dout", 32'(bus2.dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cmp_en = 0;
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 256; a++) mmem[k][a] = 8'h00;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1;

    // Fill memories with a known pattern: mem[a] = a ^ 0x5A
    for (int a = 0; a < 256; a++) begin
      cmd(2'b00, 8'(a));
      cmd(2'b01, 8'(a) ^ 8'h5A);
    end
    chk("fill u1.cmd_err", 32'(bus1.cmd_err), 32'h1);

    // Read in flight, then asynchronous reset mid-cycle
    cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00);
    chk("pre-rst u0.tx_valid", 32'(bus0.tx_valid), 32'h1);
    chk("pre-rst u0.dout", 32'(bus0.dout), 32'h4A);
    do_reset();

    // Unarmed read, then arm and read (memory kept across reset)
    cmd(2'b11, 8'h00);
    chk("unarmed u0.tx_valid", 32'(bus0.tx_valid), 32'h0);
    chk("unarmed u0.cmd_err", 32'(bus0.cmd_err), 32'h1);
    cmd(2'b10, 8'h00);
    cmd(2'b11, 8'h00);
    chk("armed u0.tx_valid", 32'(bus0.tx_valid), 32'h1);
    chk("armed u0.dout", 32'(bus0.dout), 32'h5A);
    chk("armed u0.cmd_err", 32'(bus0.cmd_err), 32'h1);
    do_reset();

    // Single access
    cmd(2'b00, 8'h10); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h10); cmd(2'b11, 8'h00);
    chk("single u0.tx_valid", 32'(bus0.tx_valid), 32'h1);
    chk("single u0.dout", 32'(bus0.dout), 32'hA5);
    chk("single u2.dout", 32'(bus2.dout), 32'hA5);
    idle();
    chk("single+1 u0.tx_valid", 32'(bus0.tx_valid), 32'h0);
    chk("single+1 u0.dout hold", 32'(bus0.dout), 32'hA5);

    // Read of a word written on the preceding edge
    cmd(2'b00, 8'h30); cmd(2'b10, 8'h30); cmd(2'b01, 8'h66); cmd(2'b11, 8'h00);
    chk("raw u0.dout", 32'(bus0.dout), 32'h66);

    // Burst across the wrap point
    cmd(2'b00, 8'hFE);
    cmd(2'b01, 8'h11); cmd(2'b01, 8'h22); cmd(2'b01, 8'h33);
    cmd(2'b10, 8'hFE);
    cmd(2'b11, 8'h00);
    chk("burst0 u0.tx_valid", 32'(bus0.tx_valid), 32'h1);
    chk("burst0 u0.dout", 32'(bus0.dout), 32'h11);
    cmd(2'b11, 8'h00);
    chk("burst1 u0.tx_valid", 32'(bus0.tx_valid), 32'h1);
    chk("burst1 u0.dout", 32'(bus0.dout), 32'h22);
    cmd(2'b11, 8'h00);
    chk("burst2 u0.tx_valid", 32'(bus0.tx_valid), 32'h1);
    chk("burst2 u0.dout", 32'(bus0.dout), 32'h33);
    idle();
    chk("burst end u0.tx_valid", 32'(bus0.tx_valid), 32'h0);
    do_reset();

    // Range error on the 200-word instance
    cmd(2'b00, 8'h05);
    cmd(2'b00, 8'hC8);
    chk("range u1.cmd_err", 32'(bus1.cmd_err), 32'h1);
    chk("range u0.cmd_err", 32'(bus0.cmd_err), 32'h0);
    cmd(2'b01, 8'h77); cmd(2'b10, 8'h05); cmd(2'b11, 8'h00);
    chk("range u1.tx_valid", 32'(bus1.tx_valid), 32'h1);
    chk("range u1.dout", 32'(bus1.dout), 32'h77);
    chk("range u0.dout", 32'(bus0.dout), 32'h5F);

    // Pointer hold with rx_valid gaps
    cmd(2'b00, 8'h03); cmd(2'b01, 8'h9C); cmd(2'b10, 8'h03); cmd(2'b11, 8'h00);
    chk("hold0 u2.tx_valid", 32'(bus2.tx_valid), 32'h1);
    chk("hold0 u2.dout", 32'(bus2.dout), 32'h9C);
    idle();
    chk("gap u2.tx_valid", 32'(bus2.tx_valid), 32'h0);
    idle();
    chk("gap2 u2.tx_valid", 32'(bus2.tx_valid), 32'h0);
    cmd(2'b11, 8'h00);
    chk("hold1 u2.tx_valid", 32'(bus2.tx_valid), 32'h1);
    chk("hold1 u2.dout", 32'(bus2.dout), 32'h9C);
    chk("hold1 u0.dout", 32'(bus0.dout), 32'h5E);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
